vec_math_pipeline: RTL and testbench
====================================

VEC_MATH_PIPELINE -- requirements
Module: vec_math_pipeline

Interface
REQ-001 SHALL have parameter SZ, default 4; vector is SZ*SZ signed 18-bit lanes, lane i at bits [18i+17:18i].
REQ-002 SHALL have parameter TW, default 1; superscalar thread ID width.
REQ-003 SHALL have parameter RW, default 5; register index width; regfile address = {thread, index}, TW+RW bits.
REQ-004 SHALL have parameter EXEC_STAGES, default 1, legal 1..4; execute pipeline depth.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port freeze  in  1  global stall; all pipeline state holds.
REQ-008 SHALL have ports in_valid in 1 / in_ready out 1  instruction handshake; transfer when both high.
REQ-009 SHALL have ports in_thread in TW, in_op in 2, in_src in RW, in_dst in RW  instruction fields.
REQ-010 SHALL have port regfile_read_addr  out  TW+RW  registered read address.
REQ-011 SHALL have port regfile_dat_r  in  SZ*SZ*18  read data, valid the cycle after regfile_read_addr.
REQ-012 SHALL have ports regfile_write_addr out TW+RW, regfile_dat_w out SZ*SZ*18, regfile_we out 1  writeback.
REQ-013 SHALL have port busy  out  1  high while any stage holds a valid instruction.

Function
REQ-014 SHALL support in_op: 0 PASS, 1 NEG, 2 RELU (negative lane -> 0), 3 ABS; all lanes processed independently.
REQ-015 SHALL saturate NEG and ABS of -131072 to +131071; no other lane wraps.
REQ-016 SHALL register regfile_read_addr = {in_thread, in_src} on the accepting edge; unchanged when nothing is accepted.
REQ-017 SHALL capture regfile_dat_r one cycle after the read address, apply op, and carry result through EXEC_STAGES registers.
REQ-018 SHALL assert regfile_we exactly 3+EXEC_STAGES cycles after acceptance (4 at default), for one cycle per instruction, with regfile_write_addr = {thread, dst}.
REQ-019 SHALL accept at most one instruction per cycle; back-to-back non-dependent instructions issue every cycle.
REQ-020 SHALL drive in_ready low when {in_thread, in_src} equals the write address of any valid in-flight instruction (RAW hazard), including the writeback stage.
REQ-021 SHALL not flag a hazard for a matching address with a different thread ID.
REQ-022 SHALL drive in_ready low whenever freeze or reset is high.
REQ-023 SHALL, during freeze, hold every stage register and gate regfile_we to 0; a held writeback fires on the first non-frozen cycle.
REQ-024 SHALL treat src == dst in one instruction as legal (no self-hazard).
REQ-025 SHALL give reset priority over freeze and in-flight work; in-flight instructions are discarded, never written back.

Reset
REQ-026 SHALL on reset clear all stage valids, regfile_read_addr, regfile_write_addr, regfile_dat_w to 0; regfile_we=0, busy=0.
REQ-027 SHALL resume accepting the cycle after reset deasserts.

Configuration
REQ-028 SHALL, with MATH_PIPE_PERF_CNT_EN defined, add output retired_count (32 bits), +1 per regfile_we pulse, wraps 0xFFFFFFFF->0, cleared by reset.
REQ-029 SHALL, without MATH_PIPE_PERF_CNT_EN, omit retired_count and its logic entirely; all other behaviour identical.

Verification
REQ-030 SHALL check: PASS thread 0 src 3 dst 7, lanes 5 accepted cycle 0 -> we at cycle 4, addr 7, lanes 5.
REQ-031 SHALL check: NEG/ABS on lane -131072 -> 131071; RELU on -1 -> 0, RELU on 9 -> 9.
REQ-032 SHALL check: write dst 4 then read src 4 same thread -> in_ready low until first instruction's we cycle passes; thread 1 src 4 accepted immediately.
REQ-033 SHALL check: freeze high 3 cycles with writeback pending -> we low during freeze, single pulse after, data unchanged.
REQ-034 SHALL check: reset asserted with 3 instructions in flight -> no we pulse, all outputs 0, busy 0 next cycle.
REQ-035 SHALL check: EXEC_STAGES=3, 10 back-to-back independent ops -> we at cycles 6..15; retired_count=10 when macro defined.

Source files
------------

// File: rtl/vec_math_pipeline.sv
// Vector lane-math pipeline: regfile read, per-lane op, EXEC_STAGES registers, writeback.
// Optional retired-instruction counter enabled by defining MATH_PIPE_PERF_CNT_EN.
module vec_math_pipeline #(
    parameter int unsigned SZ          = 4,
    parameter int unsigned TW          = 1,
    parameter int unsigned RW          = 5,
    parameter int unsigned EXEC_STAGES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   freeze,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TW-1:0]          in_thread,
    input  logic [1:0]             in_op,
    input  logic [RW-1:0]          in_src,
    input  logic [RW-1:0]          in_dst,
    output logic [TW+RW-1:0]       regfile_read_addr,
    input  logic [SZ*SZ*18-1:0]    regfile_dat_r,
    output logic [TW+RW-1:0]       regfile_write_addr,
    output logic [SZ*SZ*18-1:0]    regfile_dat_w,
    output logic                   regfile_we,
    output logic                   busy
`ifdef MATH_PIPE_PERF_CNT_EN
    ,
    output logic [31:0]            retired_count
`endif
);

    localparam int unsigned LANES = SZ * SZ;
    localparam int unsigned VW    = LANES * 18;
    localparam int unsigned AW    = TW + RW;

    localparam logic [17:0] LANE_MIN = 18'h20000;
    localparam logic [17:0] LANE_MAX = 18'h1FFFF;
    localparam logic [1:0]  OP_PASS  = 2'd0;
    localparam logic [1:0]  OP_NEG   = 2'd1;
    localparam logic [1:0]  OP_RELU  = 2'd2;

    function automatic logic [17:0] lane_op(input logic [17:0] x, input logic [1:0] op);
        logic [17:0] neg;
        neg = (x == LANE_MIN) ? LANE_MAX : (~x + 18'd1);
        case (op)
            OP_PASS: lane_op = x;
            OP_NEG:  lane_op = neg;
            OP_RELU: lane_op = x[17] ? 18'd0 : x;
            default: lane_op = x[17] ? neg : x;
        endcase
    endfunction

    logic                   s0_valid_q, s1_valid_q, wb_valid_q;
    logic [AW-1:0]          s0_addr_q, s1_addr_q;
    logic [1:0]             s0_op_q, s1_op_q;
    logic [EXEC_STAGES-1:0] ex_valid_q;
    logic [AW-1:0]          ex_addr_q [EXEC_STAGES];
    logic [VW-1:0]          ex_data_q [EXEC_STAGES];
    logic                   hold_valid_q;
    logic [VW-1:0]          hold_data_q;

    logic [AW-1:0] in_addr;
    logic          hazard;
    logic          accept;
    logic [VW-1:0] op_src;
    logic [VW-1:0] op_res;

    assign in_addr = {in_thread, in_src};

    // A writer's own src/dst overlap never stalls: only in-flight destinations are compared.
    always_comb begin
        hazard = 1'b0;
        if (s0_valid_q && (s0_addr_q == in_addr)) hazard = 1'b1;
        if (s1_valid_q && (s1_addr_q == in_addr)) hazard = 1'b1;
        for (int i = 0; i < EXEC_STAGES; i++) begin
            if (ex_valid_q[i] && (ex_addr_q[i] == in_addr)) hazard = 1'b1;
        end
        if (wb_valid_q && (regfile_write_addr == in_addr)) hazard = 1'b1;
    end

    assign in_ready   = ~reset & ~freeze & ~hazard;
    assign accept     = in_valid & in_ready;
    assign regfile_we = wb_valid_q & ~freeze & ~reset;
    assign busy       = s0_valid_q | s1_valid_q | (|ex_valid_q) | wb_valid_q;

    // Read data seen while frozen is latched, since the regfile port may move on meanwhile.
    assign op_src = hold_valid_q ? hold_data_q : regfile_dat_r;

    always_comb begin
        op_res = '0;
        for (int i = 0; i < LANES; i++) begin
            op_res[18*i +: 18] = lane_op(op_src[18*i +: 18], s1_op_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid_q         <= 1'b0;
            s1_valid_q         <= 1'b0;
            wb_valid_q         <= 1'b0;
            s0_addr_q          <= '0;
            s1_addr_q          <= '0;
            s0_op_q            <= '0;
            s1_op_q            <= '0;
            ex_valid_q         <= '0;
            for (int i = 0; i < EXEC_STAGES; i++) begin
                ex_addr_q[i] <= '0;
                ex_data_q[i] <= '0;
            end
            hold_valid_q       <= 1'b0;
            hold_data_q        <= '0;
            regfile_read_addr  <= '0;
            regfile_write_addr <= '0;
            regfile_dat_w      <= '0;
        end else if (freeze) begin
            if (s1_valid_q && !hold_valid_q) begin
                hold_valid_q <= 1'b1;
                hold_data_q  <= regfile_dat_r;
            end
        end else begin
            hold_valid_q <= 1'b0;
            s0_valid_q   <= accept;
            if (accept) begin
                s0_addr_q         <= {in_thread, in_dst};
                s0_op_q           <= in_op;
                regfile_read_addr <= in_addr;
            end
            s1_valid_q    <= s0_valid_q;
            s1_addr_q     <= s0_addr_q;
            s1_op_q       <= s0_op_q;
            ex_valid_q[0] <= s1_valid_q;
            ex_addr_q[0]  <= s1_addr_q;
            ex_data_q[0]  <= op_res;
            for (int i = 1; i < EXEC_STAGES; i++) begin
                ex_valid_q[i] <= ex_valid_q[i-1];
                ex_addr_q[i]  <= ex_addr_q[i-1];
                ex_data_q[i]  <= ex_data_q[i-1];
            end
            wb_valid_q <= ex_valid_q[EXEC_STAGES-1];
            if (ex_valid_q[EXEC_STAGES-1]) begin
                regfile_write_addr <= ex_addr_q[EXEC_STAGES-1];
                regfile_dat_w      <= ex_data_q[EXEC_STAGES-1];
            end
        end
    end

`ifdef MATH_PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_count <= '0;
        end else if (regfile_we) begin
            retired_count <= retired_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vec_math_pipeline.sv
// Directed self-checking bench for vec_math_pipeline (EXEC_STAGES=1 and EXEC_STAGES=3 instances).
// Checks retired_count as well when MATH_PIPE_PERF_CNT_EN is defined.
module tb_vec_math_pipeline;

    logic         clk = 1'b0;
    logic         reset, freeze;
    logic         v1, v3;
    logic [0:0]   thr;
    logic [1:0]   op;
    logic [4:0]   src, dst;

    logic         rdy1, we1, busy1, rdy3, we3, busy3;
    logic [5:0]   ra1, wa1, ra3, wa3;
    logic [287:0] dr1, dw1, dr3, dw3;
`ifdef MATH_PIPE_PERF_CNT_EN
    logic [31:0]  rc1, rc3;
`endif

    logic         pre_we;
    logic [5:0]   pre_addr;
    logic [287:0] pre_dat;
    logic [287:0] mem [64];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Regfile model: one-cycle registered read per DUT, preload port for the bench.
    always_ff @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_dat;
        dr1 <= mem[ra1];
        dr3 <= mem[ra3];
    end

    vec_math_pipeline d1 (
        .clk(clk), .reset(reset), .freeze(freeze), .in_valid(v1), .in_ready(rdy1),
        .in_thread(thr), .in_op(op), .in_src(src), .in_dst(dst),
        .regfile_read_addr(ra1), .regfile_dat_r(dr1), .regfile_write_addr(wa1),
        .regfile_dat_w(dw1), .regfile_we(we1), .busy(busy1)
`ifdef MATH_PIPE_PERF_CNT_EN
        , .retired_count(rc1)
`endif
    );

    vec_math_pipeline #(.EXEC_STAGES(3)) d3 (
        .clk(clk), .reset(reset), .freeze(freeze), .in_valid(v3), .in_ready(rdy3),
        .in_thread(thr), .in_op(op), .in_src(src), .in_dst(dst),
        .regfile_read_addr(ra3), .regfile_dat_r(dr3), .regfile_write_addr(wa3),
        .regfile_dat_w(dw3), .regfile_we(we3), .busy(busy3)
`ifdef MATH_PIPE_PERF_CNT_EN
        , .retired_count(rc3)
`endif
    );

    function automatic logic [287:0] fill(input int v);
        logic [287:0] r;
        for (int i = 0; i < 16; i++) r[18*i +: 18] = v[17:0];
        return r;
    endfunction

    function automatic logic [287:0] lanes3(input int a, input int b, input int c);
        logic [287:0] r;
        r = '0;
        r[17:0]  = a[17:0];
        r[35:18] = b[17:0];
        r[53:36] = c[17:0];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] a, input logic [287:0] d);
        pre_we = 1'b1; pre_addr = a; pre_dat = d;
        next_cyc();
        pre_we = 1'b0;
    endtask

    task automatic set_instr(input int t, input int o, input int s, input int d);
        thr = t[0:0]; op = o[1:0]; src = s[4:0]; dst = d[4:0];
    endtask

    logic         anyw, anyr, expw;
    int           ops_op  [5] = '{1, 3, 2, 2, 3};
    int           ops_src [5] = '{8, 8, 9, 10, 11};
    logic [287:0] ops_exp [5];
    logic [287:0] e3_exp  [4];

    initial begin
        reset = 1'b1; freeze = 1'b0; v1 = 1'b0; v3 = 1'b0; pre_we = 1'b0;
        pre_addr = '0; pre_dat = '0;
        set_instr(0, 0, 0, 0);
        ops_exp[0] = fill(131071);
        ops_exp[1] = fill(131071);
        ops_exp[2] = fill(0);
        ops_exp[3] = fill(9);
        ops_exp[4] = lanes3(131071, 7, 100);
        e3_exp[0]  = fill(5);
        e3_exp[1]  = fill(-5);
        e3_exp[2]  = fill(5);
        e3_exp[3]  = fill(5);

        next_cyc();
        load(6'd3, fill(5));
        load(6'd8, fill(-131072));
        load(6'd9, fill(-1));
        load(6'd10, fill(9));
        load(6'd11, lanes3(-131072, -7, 100));

        // Reset state
        chk("rst_read_addr", ra1, 0);
        chk("rst_write_addr", wa1, 0);
        chk("rst_dat_w", dw1, 0);
        chk("rst_we", we1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_ready_low", rdy1, 0);
        reset = 1'b0;
        next_cyc();
        chk("ready_after_reset", rdy1, 1);

        // PASS t0 src3 dst7: writeback four cycles after acceptance
        set_instr(0, 0, 3, 7); v1 = 1'b1;
        #1 chk("pass_ready", rdy1, 1);
        next_cyc();
        v1 = 1'b0;
        chk("pass_read_addr", ra1, 3);
        chk("pass_busy", busy1, 1);
        anyw = we1;
        next_cyc(); anyw |= we1;
        next_cyc(); anyw |= we1;
        chk("pass_no_early_we", anyw, 0);
        next_cyc();
        chk("pass_we", we1, 1);
        chk("pass_addr", wa1, 7);
        chk("pass_data", dw1, fill(5));
        next_cyc();
        chk("pass_we_single", we1, 0);
        chk("pass_idle", busy1, 0);

        // Ops with saturation, back to back
        for (int k = 0; k < 9; k++) begin
            if (k < 5) begin
                set_instr(0, ops_op[k], ops_src[k], k + 1);
                v1 = 1'b1;
            end else begin
                v1 = 1'b0;
            end
            #1;
            if (k < 5) chk("ops_ready", rdy1, 1);
            if (k >= 4) begin
                chk("ops_we", we1, 1);
                chk("ops_addr", wa1, 6'(k - 3));
                chk("ops_data", dw1, ops_exp[k-4]);
            end
            next_cyc();
        end
        chk("ops_we_end", we1, 0);

        // RAW hazard on same thread
        set_instr(0, 0, 3, 4); v1 = 1'b1;
        next_cyc();
        set_instr(0, 0, 4, 6);
        anyr = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1 anyr |= rdy1;
            if (c == 4) chk("raw_first_we", we1, 1);
            next_cyc();
        end
        chk("raw_stall", anyr, 0);
        #1 chk("raw_release", rdy1, 1);
        next_cyc();
        v1 = 1'b0;
        repeat (6) next_cyc();
        chk("raw_drained", busy1, 0);

        // Same index, different thread: no stall
        set_instr(0, 0, 3, 4); v1 = 1'b1;
        next_cyc();
        set_instr(1, 0, 4, 12);
        #1 chk("raw_other_thread", rdy1, 1);
        next_cyc();
        v1 = 1'b0;
        next_cyc(); next_cyc();
        chk("thr_first_addr", wa1, 6'd4);
        next_cyc();
        chk("thr_second_we", we1, 1);
        chk("thr_second_addr", wa1, 6'd44);
        repeat (3) next_cyc();

        // Freeze over a pending writeback
        set_instr(0, 1, 3, 7); v1 = 1'b1;
        next_cyc();
        v1 = 1'b0;
        repeat (3) next_cyc();
        freeze = 1'b1;
        anyw = 1'b0; anyr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 anyw |= we1; anyr |= rdy1;
            if (c == 2) chk("frz_busy", busy1, 1);
            next_cyc();
        end
        freeze = 1'b0;
        #1;
        chk("frz_no_we", anyw, 0);
        chk("frz_ready_low", anyr, 0);
        chk("frz_we_after", we1, 1);
        chk("frz_addr", wa1, 7);
        chk("frz_data", dw1, fill(-5));
        next_cyc();
        chk("frz_we_single", we1, 0);
        repeat (2) next_cyc();

        // Reset with three instructions in flight
        for (int k = 0; k < 3; k++) begin
            set_instr(0, 0, 3, 20 + k); v1 = 1'b1;
            next_cyc();
        end
        v1 = 1'b0;
        reset = 1'b1;
        #1 chk("rst2_we_now", we1, 0);
        next_cyc();
        chk("rst2_read_addr", ra1, 0);
        chk("rst2_write_addr", wa1, 0);
        chk("rst2_dat_w", dw1, 0);
        chk("rst2_we", we1, 0);
        chk("rst2_busy", busy1, 0);
        reset = 1'b0;
        #1 chk("rst2_ready", rdy1, 1);
        anyw = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1 anyw |= we1;
            next_cyc();
        end
        chk("rst2_discarded", anyw, 0);
`ifdef MATH_PIPE_PERF_CNT_EN
        chk("rst2_count_clear", rc1, 0);
`endif

        // EXEC_STAGES=3: ten independent ops, writebacks at cycles 6..15
        for (int k = 0; k < 17; k++) begin
            if (k < 10) begin
                set_instr(0, k % 4, 3, 13 + k);
                v3 = 1'b1;
            end else begin
                v3 = 1'b0;
            end
            #1;
            if (k < 10) chk("e3_ready", rdy3, 1);
            expw = (k >= 6) && (k <= 15);
            chk("e3_we", we3, expw);
            if (expw) begin
                chk("e3_addr", wa3, 6'(13 + k - 6));
                chk("e3_data", dw3, e3_exp[(k - 6) % 4]);
            end
            next_cyc();
        end
        chk("e3_idle", busy3, 0);
`ifdef MATH_PIPE_PERF_CNT_EN
        chk("e3_retired", rc3, 10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
